// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: data width, FIFO depth and idle timeout defaults.
package uart_pkg;

  localparam int UART_DATA_W              = 8;
  localparam int UART_FIFO_DEPTH_LOG2_DEF = 4;
  localparam int UART_TIMEOUT_DEF         = 50000;

endpackage : uart_pkg

// File: rtl/uart_sync_fifo.sv
// Generic show-ahead synchronous FIFO with extra-MSB pointers, occupancy count and full/empty flags.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic                  pop_i,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  push_ok, pop_ok;
  logic [DEPTH_LOG2-1:0] wr_idx, rd_next_idx;

  always_comb begin
    empty_o     = (wr_ptr_q == rd_ptr_q);
    full_o      = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                  (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    count_o     = wr_ptr_q - rd_ptr_q;
    pop_ok      = pop_i & ~empty_o;
    push_ok     = push_i & (~full_o | pop_ok);
    wr_ptr_d    = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, push_ok};
    rd_ptr_d    = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, pop_ok};
    wr_idx      = wr_ptr_q[DEPTH_LOG2-1:0];
    rd_next_idx = rd_ptr_d[DEPTH_LOG2-1:0];
    rdata_d     = rdata_q;
    // Head register reloads only when the head moves; forward the write when it lands on the new head.
    if (pop_ok || (push_ok && empty_o)) begin
      if (push_ok && (wr_idx == rd_next_idx)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_q[rd_next_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_idx] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule : uart_sync_fifo

// File: rtl/uart_rx_fifo.sv
// Captures each completed UART byte (falling edge of rx_int) into a FIFO with sticky overflow.
// Define RX_FIFO_TIMEOUT_EN to add the rx_timeout idle-flush indication.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int          DATA_W      = UART_DATA_W,
  parameter int          DEPTH_LOG2  = UART_FIFO_DEPTH_LOG2_DEF,
  parameter logic [15:0] TIMEOUT_CYC = 16'(UART_TIMEOUT_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_int,
  input  logic [DATA_W-1:0]   rx_data,
  output logic [DATA_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                overflow,
  input  logic                clr_ovf
`ifdef RX_FIFO_TIMEOUT_EN
  ,
  output logic                rx_timeout
`endif
);

  logic rx_int_q;
  logic ovf_q, ovf_d;
  logic push_req, pop, drop;
  logic empty;

  uart_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .wdata_i (rx_data),
    .pop_i   (m_ready),
    .rdata_o (m_data),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    m_valid  = ~empty;
    push_req = rx_int_q & ~rx_int;
    pop      = m_valid & m_ready;
    drop     = push_req & full & ~pop;
    ovf_d    = ovf_q;
    // A drop in the same cycle as clr_ovf must still be reported.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_int_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      rx_int_q <= rx_int;
      ovf_q    <= ovf_d;
    end
  end

  assign overflow = ovf_q;

`ifdef RX_FIFO_TIMEOUT_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (push_req || pop || !m_valid) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TIMEOUT_CYC) begin
      idle_cnt_d = idle_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign rx_timeout = (idle_cnt_q == TIMEOUT_CYC) & m_valid;
`endif

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (depth 16, timeout 20 when RX_FIFO_TIMEOUT_EN is defined).
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_int;
  logic [7:0] rx_data;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       clr_ovf;
`ifdef RX_FIFO_TIMEOUT_EN
  logic       rx_timeout;
`endif

  int checks = 0;
  int errors = 0;
  bit consume_en = 0;
  int exp_next = 0;

  uart_rx_fifo #(
    .DATA_W      (8),
    .DEPTH_LOG2  (4),
    .TIMEOUT_CYC (16'd20)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_int   (rx_int),
    .rx_data  (rx_data),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .count    (count),
    .full     (full),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
`ifdef RX_FIFO_TIMEOUT_EN
    ,
    .rx_timeout (rx_timeout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; when consuming, checks each popped byte in order and toggles m_ready.
  task automatic tick();
    if (consume_en && m_valid && m_ready) begin
      check("order_byte", 32'(m_data), 32'(exp_next));
      exp_next++;
    end
    @(posedge clk);
    #1;
    if (consume_en) m_ready = ~m_ready;
  endtask

  task automatic send_frame(input logic [7:0] b, input int hi);
    rx_int = 1'b1;
    repeat (hi) tick();
    rx_int  = 1'b0;
    rx_data = b;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; rx_int = 1'b0; rx_data = 8'h00; m_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) tick();
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(full), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_m_data", 32'(m_data), 0);
    rst_n = 1'b1;
    tick();

    // Single byte in and out
    send_frame(8'hA5, 10);
    check("single_valid", 32'(m_valid), 1);
    check("single_data", 32'(m_data), 32'hA5);
    check("single_count", 32'(count), 1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    check("single_pop_valid", 32'(m_valid), 0);
    check("single_pop_count", 32'(count), 0);
    $display("single byte: data=%h", 8'hA5);

    // 40 frames with a 50% consumer; order must be preserved across pointer wraps
    exp_next = 0; consume_en = 1; m_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      send_frame(8'(i), 2);
      $display("order frame %0d sent=%h", i, 8'(i));
    end
    for (int i = 0; i < 200 && exp_next < 40; i++) tick();
    consume_en = 0; m_ready = 1'b0;
    check("order_total", 32'(exp_next), 40);
    check("order_overflow", 32'(overflow), 0);
    check("order_empty", 32'(m_valid), 0);

    // 17 frames without consumption: last byte dropped
    for (int i = 0; i < 17; i++) send_frame(8'h60 + 8'(i), 2);
    check("ovf_full", 32'(full), 1);
    check("ovf_count", 32'(count), 16);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_head", 32'(m_data), 32'h60);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_clear", 32'(overflow), 0);
    $display("overflow: 17 frames, cleared");

    // Drop coinciding with clr_ovf: set wins
    rx_int = 1'b1; tick(); tick();
    rx_int = 1'b0; rx_data = 8'h99; clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_set_wins", 32'(overflow), 1);
    check("ovf_set_count", 32'(count), 16);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("ovf_clear2", 32'(overflow), 0);

    // Full FIFO, push and pop in the same cycle
    rx_int = 1'b1; tick(); tick();
    rx_int = 1'b0; rx_data = 8'hAB; m_ready = 1'b1; tick(); m_ready = 1'b0;
    check("fullpop_overflow", 32'(overflow), 0);
    check("fullpop_count", 32'(count), 16);
    check("fullpop_full", 32'(full), 1);
    check("fullpop_head", 32'(m_data), 32'h61);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("fullpop_drain", 32'(m_data), (i < 15) ? 32'h61 + 32'(i) : 32'hAB);
      tick();
    end
    m_ready = 1'b0;
    check("fullpop_empty", 32'(m_valid), 0);
    check("fullpop_count0", 32'(count), 0);
    $display("full+pop: tail byte=%h", 8'hAB);

    // Reset in mid-operation with a frame spanning reset release
    for (int i = 0; i < 5; i++) send_frame(8'h30 + 8'(i), 2);
    check("mid_count5", 32'(count), 5);
    rx_int = 1'b1; tick();
    rst_n = 1'b0; #1;
    check("mid_async_valid", 32'(m_valid), 0);
    check("mid_async_count", 32'(count), 0);
    tick(); tick();
    rst_n = 1'b1;
    check("mid_overflow", 32'(overflow), 0);
    check("mid_count0", 32'(count), 0);
    repeat (3) tick();
    rx_int = 1'b0; rx_data = 8'h3C; tick();
    repeat (3) tick();
    check("mid_one_push", 32'(count), 1);
    check("mid_data", 32'(m_data), 32'h3C);
    $display("reset mid-operation: one push data=%h", 8'h3C);

`ifdef RX_FIFO_TIMEOUT_EN
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    send_frame(8'h77, 2);
    check("tmo_at_push", 32'(rx_timeout), 0);
    repeat (19) tick();
    check("tmo_19", 32'(rx_timeout), 0);
    tick();
    check("tmo_20", 32'(rx_timeout), 1);
    tick();
    check("tmo_hold", 32'(rx_timeout), 1);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    check("tmo_pop", 32'(rx_timeout), 0);
    $display("timeout: asserted 20 cycles after push");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx_fifo
